cw305_usb_bus_master: RTL and testbench

- Initiator for the CW305 parallel USB register bus; drives the same protocol that the register front end (cw305_usb_reg_fe) answers.
- Converts byte-burst commands into cen/wrn/rdn/addr/data cycles with programmable setup/strobe/hold timing.
- Used in SS2-style wrappers and self-test benches to act as the host side of the bus.

---
 rtl/cw305_usb_bus_pkg.sv | 20 ++
 rtl/cw305_usb_bus_master.sv | 183 ++++++++++++++++++
 tb/tb_cw305_usb_bus_master.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cw305_usb_bus_pkg.sv
// Shared types and helpers for the CW305 USB register-bus master.
// Holds the burst FSM encoding, the minimum phase length and cmd_len width.
package cw305_usb_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAITD,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } bus_state_t;

    localparam int MIN_TIMING = 1;

    function automatic int len_width(input int bytecnt_size);
        return bytecnt_size + 1;
    endfunction

endpackage

// File: rtl/cw305_usb_bus_master.sv
// Host-side initiator for the CW305 parallel USB register bus.
// Optional counters: define CW305_BUSMASTER_STATS_EN.
module cw305_usb_bus_master
    import cw305_usb_bus_pkg::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pSETUP        = 1,
    parameter int pSTROBE       = 2,
    parameter int pHOLD         = 1
) (
    input  logic                                  usb_clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic                                  cmd_write,
    input  logic [pADDR_WIDTH-1:0]                cmd_addr,
    input  logic [len_width(pBYTECNT_SIZE)-1:0]   cmd_len,
    input  logic [7:0]                            wdata,
    input  logic                                  wdata_valid,
    output logic                                  wdata_ready,
    output logic [7:0]                            rdata,
    output logic                                  rdata_valid,
    input  logic                                  rdata_ready,
    output logic                                  cmd_done,
    output logic                                  busy,
    output logic [pADDR_WIDTH-1:0]                usb_addr,
    output logic [7:0]                            usb_dout,
    output logic                                  usb_dout_en,
    input  logic [7:0]                            usb_din,
    output logic                                  usb_cen,
    output logic                                  usb_wrn,
    output logic                                  usb_rdn
`ifdef CW305_BUSMASTER_STATS_EN
    ,
    output logic [31:0]                           stat_wr_bytes,
    output logic [31:0]                           stat_rd_bytes
`endif
);

    localparam int LW = len_width(pBYTECNT_SIZE);
    localparam int CW = 16;
    localparam int BC = pBYTECNT_SIZE;

    generate
        if (pSETUP < MIN_TIMING || pSTROBE < MIN_TIMING || pHOLD < MIN_TIMING) begin : g_bad_timing
            $error("cw305_usb_bus_master: pSETUP/pSTROBE/pHOLD must be >= 1");
        end
    endgenerate

    bus_state_t      state;
    bus_state_t      next_state;
    logic [CW-1:0]   cnt;
    logic [LW-1:0]   rem;
    logic            wr_mode;
    logic            phase_end;
    logic            strobe_end;

    assign phase_end  = (cnt == '0);
    assign strobe_end = (state == ST_STROBE) && phase_end;

    function automatic logic [CW-1:0] phase_load(input bus_state_t s);
        case (s)
            ST_SETUP:  return CW'(pSETUP - 1);
            ST_STROBE: return CW'(pSTROBE - 1);
            ST_HOLD:   return CW'(pHOLD - 1);
            default:   return '0;
        endcase
    endfunction

    // State register.
    always_ff @(posedge usb_clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state and bus strobe/handshake decode.
    always_comb begin
        next_state  = state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        cmd_done    = 1'b0;
        wdata_ready = 1'b0;
        usb_cen     = 1'b1;
        usb_wrn     = 1'b1;
        usb_rdn     = 1'b1;
        usb_dout_en = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid)
                    next_state = (cmd_len == '0) ? ST_DONE : ST_WAITD;
            end
            ST_WAITD: begin
                if (wr_mode) begin
                    wdata_ready = wdata_valid;
                    if (wdata_valid) next_state = ST_SETUP;
                end else if (!rdata_valid) begin
                    next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                usb_cen     = 1'b0;
                usb_dout_en = wr_mode;
                if (phase_end) next_state = ST_STROBE;
            end
            ST_STROBE: begin
                usb_cen     = 1'b0;
                usb_dout_en = wr_mode;
                usb_wrn     = !wr_mode;
                usb_rdn     = wr_mode;
                if (phase_end) next_state = ST_HOLD;
            end
            ST_HOLD: begin
                usb_cen     = 1'b0;
                usb_dout_en = wr_mode;
                if (phase_end)
                    next_state = (rem > LW'(1)) ? ST_WAITD : ST_DONE;
            end
            ST_DONE: begin
                cmd_done   = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Phase down-counter, reloaded whenever a new phase is entered.
    always_ff @(posedge usb_clk) begin
        if (rst)                       cnt <= '0;
        else if (next_state != state)  cnt <= phase_load(next_state);
        else if (cnt != '0)            cnt <= cnt - CW'(1);
    end

    // Command latch, address/data registers and the one-entry read buffer.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            wr_mode     <= 1'b0;
            rem         <= '0;
            usb_addr    <= '0;
            usb_dout    <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                wr_mode  <= cmd_write;
                usb_addr <= cmd_addr;
                rem      <= cmd_len;
            end
            if (state == ST_WAITD && wr_mode && wdata_valid)
                usb_dout <= wdata;
            if (state == ST_HOLD && phase_end && rem > LW'(1)) begin
                rem <= rem - LW'(1);
                usb_addr[BC-1:0] <= usb_addr[BC-1:0] + BC'(1);
            end
            if (rdata_valid && rdata_ready)
                rdata_valid <= 1'b0;
            if (strobe_end && !wr_mode) begin
                rdata       <= usb_din;
                rdata_valid <= 1'b1;
            end
        end
    end

`ifdef CW305_BUSMASTER_STATS_EN
    // Saturating per-direction byte counters, bumped at each strobe end.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            stat_wr_bytes <= '0;
            stat_rd_bytes <= '0;
        end else if (strobe_end) begin
            if (wr_mode && stat_wr_bytes != 32'hFFFF_FFFF)
                stat_wr_bytes <= stat_wr_bytes + 32'd1;
            if (!wr_mode && stat_rd_bytes != 32'hFFFF_FFFF)
                stat_rd_bytes <= stat_rd_bytes + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_cw305_usb_bus_master.sv
// Randomized scoreboard bench for cw305_usb_bus_master.
// Bus target memory, write feeder and read sink are modelled here.
module tb_cw305_usb_bus_master;

    localparam int P_SETUP  = 1;
    localparam int P_STROBE = 2;
    localparam int P_HOLD   = 1;
    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          kind;
        logic [20:0] addr;
        logic [7:0]  data;
        int          len;
    } exp_t;

    typedef logic [7:0] byte_q_t[$];

    logic        usb_clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [20:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [7:0]  wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        rdata_ready = 1'b0;
    logic        cmd_done;
    logic        busy;
    logic [20:0] usb_addr;
    logic [7:0]  usb_dout;
    logic        usb_dout_en;
    logic [7:0]  usb_din;
    logic        usb_cen, usb_wrn, usb_rdn;
`ifdef CW305_BUSMASTER_STATS_EN
    logic [31:0] stat_wr, stat_rd;
`endif

    logic [7:0] mem [0:127];
    logic [7:0] shadow [0:127];
    exp_t       bus_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] wq[$];
    int         checks = 0;
    int         errors = 0;
    int         rd_stall = 0;

    assign usb_din = mem[usb_addr[6:0]];

    always #5 usb_clk = ~usb_clk;

    cw305_usb_bus_master dut (
        .usb_clk(usb_clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .cmd_done(cmd_done), .busy(busy),
        .usb_addr(usb_addr), .usb_dout(usb_dout), .usb_dout_en(usb_dout_en),
        .usb_din(usb_din),
        .usb_cen(usb_cen), .usb_wrn(usb_wrn), .usb_rdn(usb_rdn)
`ifdef CW305_BUSMASTER_STATS_EN
        , .stat_wr_bytes(stat_wr), .stat_rd_bytes(stat_rd)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Write-data source: random gaps, pops a byte once it was taken.
    initial begin
        logic took;
        forever begin
            @(negedge usb_clk);
            took = wdata_valid && wdata_ready;
            @(posedge usb_clk);
            #1;
            if (took && wq.size() > 0) void'(wq.pop_front());
            wdata_valid = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
            wdata = (wq.size() > 0) ? wq[0] : 8'h00;
        end
    end

    // Read sink: random ready, or held low for rd_stall cycles of valid data.
    initial begin
        forever begin
            @(posedge usb_clk);
            #1;
            if (rd_stall > 0) begin
                rdata_ready = 1'b0;
                if (rdata_valid) rd_stall--;
            end else begin
                rdata_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: bus protocol checks plus scoreboard pops.
    initial begin
        logic prev_wrn, prev_rdn, prev_cen, prev_ready;
        int   strobe_run, cen_run;
        exp_t e;
        logic [7:0] rexp;
        prev_wrn = 1; prev_rdn = 1; prev_cen = 1; prev_ready = 1;
        strobe_run = 0; cen_run = 0;
        forever begin
            @(negedge usb_clk);
            if (rst) begin
                prev_wrn = 1; prev_rdn = 1; prev_cen = 1; prev_ready = 1;
                strobe_run = 0; cen_run = 0;
                continue;
            end
            if (!usb_wrn || !usb_rdn) begin
                chk("strobe_excl", 32'(usb_wrn | usb_rdn), 1);
                chk("cen_with_strobe", 32'(usb_cen), 0);
            end
            if (!usb_rdn) chk("dout_en_read", 32'(usb_dout_en), 0);
            if (!usb_wrn) mem[usb_addr[6:0]] = usb_dout;
            if (!usb_wrn && prev_wrn) begin
                if (bus_q.size() == 0) fail_now("unexpected_write");
                else begin
                    e = bus_q.pop_front();
                    chk("wr_kind", e.kind, K_WR);
                    chk("wr_addr", 32'(usb_addr), 32'(e.addr));
                    chk("wr_data", 32'(usb_dout), 32'(e.data));
                    chk("wr_dout_en", 32'(usb_dout_en), 1);
                end
            end
            if (!usb_rdn && prev_rdn) begin
                if (bus_q.size() == 0) fail_now("unexpected_read");
                else begin
                    e = bus_q.pop_front();
                    chk("rd_kind", e.kind, K_RD);
                    chk("rd_addr", 32'(usb_addr), 32'(e.addr));
                    chk("rd_buf_free", 32'(rdata_valid), 0);
                end
            end
            if (!usb_wrn || !usb_rdn) strobe_run++;
            else if (strobe_run > 0) begin
                chk("strobe_len", strobe_run, P_STROBE);
                strobe_run = 0;
            end
            if (!usb_cen) cen_run++;
            else if (cen_run > 0) begin
                chk("cen_len", cen_run, P_SETUP + P_STROBE + P_HOLD);
                cen_run = 0;
            end
            if (cmd_done) begin
                if (bus_q.size() == 0) fail_now("unexpected_done");
                else begin
                    e = bus_q.pop_front();
                    chk("done_kind", e.kind, K_DONE);
                    if (e.len > 0)
                        chk("done_after_hold", 32'({prev_cen, prev_wrn, prev_rdn}), 3'b011);
                    else
                        chk("done_after_accept", 32'(prev_ready), 1);
                    chk("done_cen", 32'(usb_cen), 1);
                    chk("done_dout_en", 32'(usb_dout_en), 0);
                end
            end
            if (rdata_valid && rdata_ready) begin
                if (rd_q.size() == 0) fail_now("unexpected_rdata");
                else begin
                    rexp = rd_q.pop_front();
                    chk("rdata", 32'(rdata), 32'(rexp));
                end
            end
            prev_wrn = usb_wrn;
            prev_rdn = usb_rdn;
            prev_cen = usb_cen;
            prev_ready = cmd_ready;
        end
    end

    function automatic logic [20:0] byte_addr(input logic [20:0] a, input int i);
        logic [6:0] lo;
        lo = a[6:0] + 7'(i);
        return {a[20:7], lo};
    endfunction

    task automatic issue(input logic w, input logic [20:0] a, input int len);
        int n;
        @(posedge usb_clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = 8'(len);
        n = 0;
        do begin
            @(negedge usb_clk);
            n++;
        end while (!cmd_ready && n < 100);
        if (!cmd_ready) fail_now("accept_timeout");
        @(posedge usb_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic w, input logic [20:0] a, input int len, input byte_q_t d);
        exp_t e;
        logic [20:0] ai;
        int n;
        while (d.size() < len) d.push_back(8'($urandom));
        for (int i = 0; i < len; i++) begin
            ai = byte_addr(a, i);
            e.addr = ai;
            e.len = 0;
            if (w) begin
                e.kind = K_WR;
                e.data = d[i];
                wq.push_back(d[i]);
                shadow[ai[6:0]] = d[i];
            end else begin
                e.kind = K_RD;
                e.data = 8'h00;
                rd_q.push_back(shadow[ai[6:0]]);
            end
            bus_q.push_back(e);
        end
        e.kind = K_DONE;
        e.addr = '0;
        e.data = '0;
        e.len = len;
        bus_q.push_back(e);
        issue(w, a, len);
        n = 0;
        while ((bus_q.size() > 0 || rd_q.size() > 0) && n < 4000) begin
            @(negedge usb_clk);
            n++;
        end
        if (n >= 4000) begin
            fail_now("drain_timeout");
            bus_q.delete();
            rd_q.delete();
            wq.delete();
        end
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        byte_q_t d;
        exp_t e;
        int n;
        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'($urandom);
            shadow[i] = mem[i];
        end
        mem[16] = 8'hA5; shadow[16] = 8'hA5;
        mem[17] = 8'h5A; shadow[17] = 8'h5A;

        rst = 1'b1;
        repeat (3) @(posedge usb_clk);
        @(negedge usb_clk);
        chk("rst_cen", 32'(usb_cen), 1);
        chk("rst_wrn", 32'(usb_wrn), 1);
        chk("rst_rdn", 32'(usb_rdn), 1);
        chk("rst_dout_en", 32'(usb_dout_en), 0);
        chk("rst_addr", 32'(usb_addr), 0);
        chk("rst_dout", 32'(usb_dout), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(cmd_done), 0);
        chk("rst_rdata_valid", 32'(rdata_valid), 0);
        chk("rst_wdata_ready", 32'(wdata_ready), 0);
        @(posedge usb_clk);
        #1;
        rst = 1'b0;

        d = '{8'h11, 8'h22, 8'h33};
        run_cmd(1'b1, 21'h000A05, 3, d);
        d = {};
        run_cmd(1'b0, 21'h000010, 2, d);
        rd_stall = 10;
        run_cmd(1'b0, 21'h000A05, 3, d);
        run_cmd(1'b1, 21'h00007F, 2, d);
        run_cmd(1'b0, 21'h1ABCFF, 3, d);
        run_cmd(1'b0, 21'h00007F, 2, d);
        run_cmd(1'b1, 21'h012345, 0, d);

        // Reset in the second STROBE cycle of a write.
        wq.push_back(8'hC3);
        wq.push_back(8'h3C);
        wq.push_back(8'h99);
        e.kind = K_WR; e.addr = 21'h000A40; e.data = 8'hC3; e.len = 0;
        bus_q.push_back(e);
        shadow[7'h40] = 8'hC3;
        issue(1'b1, 21'h000A40, 3);
        n = 0;
        while (usb_wrn && n < 200) begin
            @(negedge usb_clk);
            n++;
        end
        if (usb_wrn) fail_now("reset_test_no_strobe");
        @(posedge usb_clk);
        #1;
        rst = 1'b1;
        @(posedge usb_clk);
        @(negedge usb_clk);
        chk("mid_rst_wrn", 32'(usb_wrn), 1);
        chk("mid_rst_cen", 32'(usb_cen), 1);
        chk("mid_rst_dout_en", 32'(usb_dout_en), 0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_rst_done", 32'(cmd_done), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_addr", 32'(usb_addr), 0);
        @(posedge usb_clk);
        #1;
        rst = 1'b0;
        wq.delete();
        repeat (3) @(negedge usb_clk);
        chk("mid_rst_no_done", 32'(bus_q.size()), 0);
        bus_q.delete();

        run_cmd(1'b1, 21'h055501, 128, d);
        run_cmd(1'b0, 21'h055501, 5, d);
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 4) == 0) rd_stall = $urandom_range(1, 8);
            run_cmd(1'($urandom_range(0, 1)), 21'($urandom), $urandom_range(0, 6), d);
        end

        repeat (5) @(negedge usb_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
